level_dequantizer: RTL and testbench
====================================

LEVEL_DEQUANTIZER -- requirements
Module: level_dequantizer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the frame and illegal-code counters.
REQ-002 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  input level code valid.
REQ-005 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-006 SHALL have port in_level  input  4  quantization level code (legal 0..9).
REQ-007 SHALL have port in_last  input  1  marks final sample of a frame.
REQ-008 SHALL have port out_valid  output  1  reconstructed sample valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts output.
REQ-010 SHALL have port out_value  output  16  reconstructed value, signed two's complement.
REQ-011 SHALL have port out_last  output  1  in_last carried with the sample.
REQ-012 SHALL have port out_illegal  output  1  sample came from an illegal code.
REQ-013 SHALL have port frame_count  output  CNT_W  number of frames completed at the output.
REQ-014 SHALL have port illegal_count  output  CNT_W  number of illegal codes emitted.

Function
REQ-015 SHALL map levels to values: 0->9999, 1->7777, 2->5555, 3->3333, 4->1111, 5->-1111, 6->-3334, 7->-5556, 8->-7778, 9->-9999, so that re-quantizing any output yields the original level.
REQ-016 SHALL map codes 10..15 to out_value 0 with out_illegal=1; legal codes SHALL give out_illegal=0.
REQ-017 SHALL transfer on the input when in_valid&&in_ready and on the output when out_valid&&out_ready.
REQ-018 SHALL be a two-stage pipeline (S1 lookup register, S2 output register), each stage ready = !valid || next stage ready.
REQ-019 SHALL present a sample accepted at edge N on out_valid after edge N+2 when out_ready stays high (latency 2, throughput 1 per cycle).
REQ-020 SHALL hold out_value, out_last, out_illegal and out_valid stable while out_valid&&!out_ready.
REQ-021 SHALL keep in_ready low only when both stages are valid and out_ready is low; no sample SHALL be dropped or duplicated.
REQ-022 SHALL have in_ready depend combinationally on out_ready; no other combinational input-to-output path SHALL exist.
REQ-023 SHALL track frame state IDLE/IN_FRAME on output transfers: IDLE->IN_FRAME on a non-last transfer, IN_FRAME->IDLE on a last transfer, a last transfer in IDLE is a one-sample frame.
REQ-024 SHALL increment frame_count by 1 on every output transfer with out_last=1, wrapping at 2^CNT_W.
REQ-025 SHALL increment illegal_count by 1 on every output transfer with out_illegal=1, saturating at 2^CNT_W-1.
REQ-026 SHALL count each transfer exactly once when the last and illegal flags are both set on it.

Reset
REQ-027 SHALL on rst clear both stage valids and set out_valid=0, out_value=0, out_last=0, out_illegal=0, frame_count=0, illegal_count=0, frame state IDLE.
REQ-028 SHALL drive in_ready=1 in the cycle after reset is released.
REQ-029 SHALL discard in-flight samples when rst is asserted mid-frame, and in_ready SHALL be 0 while rst is high.

Structure
REQ-030 SHALL place the level-to-value constants, NUM_LEVELS=10 and the frame-state enum in the shared HDC package used by the quantizer.
REQ-031 SHALL implement the combinational lookup as one sub-module, level_to_value, instanced in S1.

Verification
REQ-032 SHALL stream levels 0..9 with out_ready=1 -> 9999,7777,5555,3333,1111,-1111,-3334,-5556,-7778,-9999, first out_valid 2 cycles after first accept, one per cycle.
REQ-033 SHALL send code 12 then code 4 -> out_value 0 with out_illegal=1, then 1111 with out_illegal=0; illegal_count=1.
REQ-034 SHALL hold out_ready=0 for 5 cycles while driving 4 samples -> in_ready falls after 2 accepts, output stable, all 4 emitted in order once released.
REQ-035 SHALL send 3 frames of lengths 1, 4, 2 (in_last on final sample) -> frame_count 1, 2, 3 after each last transfer, out_last aligned to those samples.
REQ-036 SHALL assert rst for one cycle mid-frame with 2 samples in flight -> no output from them, counters 0, frame state IDLE; next frame processed normally.
REQ-037 SHALL with CNT_W=4 send 20 illegal codes -> illegal_count saturates at 15.

Source files
------------

// File: rtl/level_dequantizer_pkg.sv
// Shared constants and types for the level dequantizer: reconstruction values
// per quantization level and the output-side frame state.
package level_dequantizer_pkg;

    localparam logic [3:0] NUM_LEVELS = 4'd10;
    localparam int         VALUE_W    = 16;

    // Midpoints chosen so that re-quantizing each value lands back on its level.
    localparam logic signed [VALUE_W-1:0] LEVEL_VALUES [10] = '{
        16'sd9999,  16'sd7777,  16'sd5555,  16'sd3333,  16'sd1111,
        -16'sd1111, -16'sd3334, -16'sd5556, -16'sd7778, -16'sd9999
    };

    typedef enum logic {
        FRAME_IDLE = 1'b0,
        FRAME_IN   = 1'b1
    } frame_state_t;

endpackage

// File: rtl/level_dequantizer_level_to_value.sv
// Combinational level-code lookup; codes beyond the legal range give zero
// and raise the illegal flag.
module level_to_value
    import level_dequantizer_pkg::*;
(
    input  logic [3:0]         level,
    output logic [VALUE_W-1:0] value,
    output logic               illegal
);

    always_comb begin
        value   = '0;
        illegal = (level >= NUM_LEVELS);
        for (int i = 0; i < 10; i++) begin
            if (level == 4'(i)) begin
                value = LEVEL_VALUES[i];
            end
        end
    end

endmodule

// File: rtl/level_dequantizer.sv
// Two-stage valid/ready dequantizer (S1 lookup register, S2 output register)
// with output-side frame and illegal-code counters.
//
//   state      | meaning
//   FRAME_IDLE | between frames; next output transfer starts a frame
//   FRAME_IN   | at least one non-last sample of the current frame emitted
module level_dequantizer
    import level_dequantizer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_level,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_value,
    output logic             out_last,
    output logic             out_illegal,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] illegal_count
);

    logic               s1_valid;
    logic [VALUE_W-1:0] s1_value;
    logic               s1_last;
    logic               s1_illegal;
    logic [VALUE_W-1:0] lut_value;
    logic               lut_illegal;
    logic               s1_ready;
    logic               s2_ready;
    logic               out_xfer;
    frame_state_t       frame_state;

    level_to_value u_lut (
        .level   (in_level),
        .value   (lut_value),
        .illegal (lut_illegal)
    );

    assign s2_ready = !out_valid || out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    // Reset holds off upstream so nothing is accepted into a pipeline being cleared.
    assign in_ready = s1_ready && !rst;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_value      <= '0;
            s1_last       <= 1'b0;
            s1_illegal    <= 1'b0;
            out_valid     <= 1'b0;
            out_value     <= '0;
            out_last      <= 1'b0;
            out_illegal   <= 1'b0;
            frame_count   <= '0;
            illegal_count <= '0;
            frame_state   <= FRAME_IDLE;
        end else begin
            if (s1_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_value   <= lut_value;
                    s1_last    <= in_last;
                    s1_illegal <= lut_illegal;
                end
            end

            if (s2_ready) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_value   <= s1_value;
                    out_last    <= s1_last;
                    out_illegal <= s1_illegal;
                end
            end

            if (out_xfer) begin
                if (out_last) begin
                    frame_count <= frame_count + 1'b1;
                end
                if (out_illegal && (illegal_count != {CNT_W{1'b1}})) begin
                    illegal_count <= illegal_count + 1'b1;
                end
                case (frame_state)
                    FRAME_IDLE: if (!out_last) frame_state <= FRAME_IN;
                    FRAME_IN:   if (out_last)  frame_state <= FRAME_IDLE;
                    default:    frame_state <= FRAME_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_level_dequantizer.sv
// Self-checking bench: vector table plus hand sequences feeding a scoreboard.
module tb_level_dequantizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last;
    logic [3:0]  in_level;
    logic        out_valid, out_ready, out_last, out_illegal;
    logic [15:0] out_value;
    logic [15:0] frame_count, illegal_count;

    logic        in_valid4, in_ready4, in_last4;
    logic [3:0]  in_level4;
    logic        out_valid4, out_last4, out_illegal4;
    logic        out_ready4;
    logic [15:0] out_value4;
    logic [3:0]  frame_count4, illegal_count4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int   value;
        logic last;
        logic ill;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [3:0] level;
        logic       last;
        int         value;
        logic       ill;
    } vec_t;
    vec_t vecs[12];

    int   exp_frames = 0;
    int   exp_ill = 0;
    logic lat_armed = 1'b0;
    int   first_acc = -1, first_out = -1, last_xfer = -1;
    logic track_stall = 1'b0;
    int   accepts = 0, stall_at = -1;
    logic held = 1'b0;
    logic [15:0] held_value;
    logic held_last, held_ill;

    level_dequantizer #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_level(in_level), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
        .out_last(out_last), .out_illegal(out_illegal),
        .frame_count(frame_count), .illegal_count(illegal_count)
    );

    level_dequantizer #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_level(in_level4), .in_last(in_last4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_value(out_value4),
        .out_last(out_last4), .out_illegal(out_illegal4),
        .frame_count(frame_count4), .illegal_count(illegal_count4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int ref_val(input logic [3:0] lvl);
        case (lvl)
            4'd0: return 9999;
            4'd1: return 7777;
            4'd2: return 5555;
            4'd3: return 3333;
            4'd4: return 1111;
            4'd5: return -1111;
            4'd6: return -3334;
            4'd7: return -5556;
            4'd8: return -7778;
            4'd9: return -9999;
            default: return 0;
        endcase
    endfunction

    // Output monitor: scoreboard pops, counter model, stall stability.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            exp_frames = 0;
            exp_ill = 0;
            held = 1'b0;
        end else begin
            check("frame_count", int'(frame_count), exp_frames);
            check("illegal_count", int'(illegal_count), exp_ill);
            if (held) begin
                check("stall_valid", int'(out_valid), 1);
                check("stall_value", int'(out_value), int'(held_value));
                check("stall_last", int'(out_last), int'(held_last));
                check("stall_illegal", int'(out_illegal), int'(held_ill));
            end
            if (lat_armed && out_valid && first_out < 0) first_out = cyc;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", int'($signed(out_value)), 99999);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_value", int'($signed(out_value)), e.value);
                    check("out_last", int'(out_last), int'(e.last));
                    check("out_illegal", int'(out_illegal), int'(e.ill));
                    if (e.last) exp_frames = (exp_frames + 1) % 65536;
                    if (e.ill && exp_ill < 65535) exp_ill++;
                end
                last_xfer = cyc;
            end
            held       = out_valid && !out_ready;
            held_value = out_value;
            held_last  = out_last;
            held_ill   = out_illegal;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the sample is accepted.
    task automatic send(input logic [3:0] lvl, input logic lst, input int ev, input logic ei);
        int waited = 0;
        in_valid = 1'b1;
        in_level = lvl;
        in_last  = lst;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            if (track_stall && stall_at < 0) stall_at = accepts;
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("send_timeout", 0, 1);
        end else begin
            exp_t e;
            e.value = ev;
            e.last  = lst;
            e.ill   = ei;
            sb.push_back(e);
            accepts++;
            if (lat_armed && first_acc < 0) first_acc = cyc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_ref(input logic [3:0] lvl, input logic lst);
        send(lvl, lst, ref_val(lvl), lvl > 4'd9);
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        in_valid4 = 1'b0;
        @(negedge clk);
        check("in_ready_in_rst", int'(in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_value", int'(out_value), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_out_illegal", int'(out_illegal), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, acc;
        rst = 1'b1;
        in_valid = 1'b0; in_level = '0; in_last = 1'b0; out_ready = 1'b1;
        in_valid4 = 1'b0; in_level4 = 4'd15; in_last4 = 1'b1; out_ready4 = 1'b1;

        for (int i = 0; i < 10; i++) begin
            vecs[i].level = 4'(i);
            vecs[i].last  = (i == 9);
            vecs[i].ill   = 1'b0;
        end
        vecs[0].value = 9999;   vecs[1].value = 7777;   vecs[2].value = 5555;
        vecs[3].value = 3333;   vecs[4].value = 1111;   vecs[5].value = -1111;
        vecs[6].value = -3334;  vecs[7].value = -5556;  vecs[8].value = -7778;
        vecs[9].value = -9999;
        vecs[10] = '{level: 4'd12, last: 1'b0, value: 0,    ill: 1'b1};
        vecs[11] = '{level: 4'd4,  last: 1'b1, value: 1111, ill: 1'b0};

        repeat (2) @(posedge clk);
        do_reset();

        // Full level sweep at full rate, latency and throughput measured.
        lat_armed = 1'b1;
        for (int i = 0; i < 10; i++) send(vecs[i].level, vecs[i].last, vecs[i].value, vecs[i].ill);
        drain();
        lat_armed = 1'b0;
        check("latency", first_out - first_acc, 2);
        check("throughput", last_xfer - first_out, 9);
        check("sweep_frames", int'(frame_count), 1);

        // Illegal code followed by a legal one.
        do_reset();
        for (int i = 10; i < 12; i++) send(vecs[i].level, vecs[i].last, vecs[i].value, vecs[i].ill);
        drain();
        check("illegal_count_1", int'(illegal_count), 1);

        // Backpressure: downstream stalled for 5 cycles while 4 samples are offered.
        do_reset();
        out_ready = 1'b0;
        accepts = 0;
        stall_at = -1;
        track_stall = 1'b1;
        fork
            begin
                send_ref(4'd3, 1'b0);
                send_ref(4'd7, 1'b0);
                send_ref(4'd0, 1'b0);
                send_ref(4'd9, 1'b1);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        track_stall = 1'b0;
        drain();
        check("stall_after_accepts", stall_at, 2);
        check("stall_frames", int'(frame_count), 1);

        // Frames of length 1, 4 and 2.
        do_reset();
        send_ref(4'd5, 1'b1);
        drain();
        check("frames_after_1", int'(frame_count), 1);
        send_ref(4'd1, 1'b0); send_ref(4'd2, 1'b0); send_ref(4'd13, 1'b0); send_ref(4'd8, 1'b1);
        drain();
        check("frames_after_2", int'(frame_count), 2);
        send_ref(4'd6, 1'b0); send_ref(4'd4, 1'b1);
        drain();
        check("frames_after_3", int'(frame_count), 3);

        // Reset mid-frame with two samples in flight.
        do_reset();
        send_ref(4'd1, 1'b0);
        drain();
        check("state_in_frame", int'(dut.frame_state), 1);
        out_ready = 1'b0;
        send_ref(4'd2, 1'b0);
        send_ref(4'd3, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("in_ready_mid_rst", int'(in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("flushed_out_valid", int'(out_valid), 0);
        end
        check("flush_frames", int'(frame_count), 0);
        check("flush_illegal", int'(illegal_count), 0);
        check("flush_state", int'(dut.frame_state), 0);
        @(posedge clk);
        #1;
        send_ref(4'd7, 1'b0);
        send_ref(4'd9, 1'b1);
        drain();
        check("post_flush_frames", int'(frame_count), 1);

        // Narrow counters: illegal saturates, frame count wraps.
        do_reset();
        in_valid4 = 1'b1;
        n = 0;
        acc = 0;
        while (acc < 20 && n < 200) begin
            @(negedge clk);
            if (in_ready4) acc++;
            n++;
            @(posedge clk);
            #1;
        end
        in_valid4 = 1'b0;
        check("narrow_accepts", acc, 20);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("illegal_saturate", int'(illegal_count4), 15);
        check("frame_wrap", int'(frame_count4), 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
